// File: rtl/md_dest_scoreboard.sv
// md_dest_scoreboard: in-order FIFO of pending mult/div destination tags.
// Pops the oldest tag as the writeback address on each completion pulse.
// Also flags RAW hazards for two decode-stage source registers against every pending tag.
// Optional build macro MD_SCOREBOARD_BYPASS_EN: the head entry is excluded from the
// hazard compare in any cycle that pops it, because its value is forwarded that cycle.
module md_dest_scoreboard #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [4:0]    issue_tag,
  output logic          issue_ready,
  input  logic          done,
  output logic          wb_valid,
  output logic [4:0]    wb_tag,
  input  logic [4:0]    src_a,
  input  logic [4:0]    src_b,
  output logic          hazard_a,
  output logic          hazard_b,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          err_overflow,
  output logic          err_underflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       tag_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q, unf_q;
  logic             push, pop;
  logic [DEPTH-1:0] cmp_valid;

  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign issue_ready   = !full;
  assign count         = count_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

  assign push     = issue_valid && !full;
  assign pop      = done && !empty;
  assign wb_valid = pop;
  assign wb_tag   = tag_q[rd_ptr_q];

  // Tag payload storage; only the valid bits need a reset.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      tag_q[wr_ptr_q] <= issue_tag;
    end
  end

  // Pointers, valid bits, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      // Push and pop never target the same slot: that needs full (no push) or empty (no pop).
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (issue_valid && full) ovf_q <= 1'b1;
      if (done && empty)       unf_q <= 1'b1;
    end
  end

`ifdef MD_SCOREBOARD_BYPASS_EN
  // Head being written back this cycle is forwarded, so it no longer blocks decode.
  always_comb begin
    cmp_valid = valid_q;
    if (pop) cmp_valid[rd_ptr_q] = 1'b0;
  end
`else
  assign cmp_valid = valid_q;
`endif

  // Associative compare of both sources against all live entries; r0 never hazards.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (cmp_valid[i] && (tag_q[i] == src_a)) hazard_a = 1'b1;
      if (cmp_valid[i] && (tag_q[i] == src_b)) hazard_b = 1'b1;
    end
    if (src_a == 5'd0) hazard_a = 1'b0;
    if (src_b == 5'd0) hazard_b = 1'b0;
  end

endmodule

// File: doc/md_dest_scoreboard.md
Name: md_dest_scoreboard

Overview:
- Consumer side of the in-flight destination-register tags captured by the 5-bit tag latches.
- Issue logic pushes the 5-bit destination tag of each long-latency (mult/div) op. The completion pulse pops the oldest tag and presents it as the writeback address.
- In parallel, flags RAW hazards for the decode stage's two source registers against every pending tag.
- Sits between decode/issue and the multdiv writeback mux.

Parameters:
- DEPTH, 4, maximum number of in-flight tags. Power of two, 2..16.
- CW, $clog2(DEPTH)+1, width of the occupancy count. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- issue_valid  input  1  request to push issue_tag
- issue_tag  input  5  destination register of the issuing op
- issue_ready  output  1  space available (= !full)
- done  input  1  one-cycle completion pulse from the multdiv unit
- wb_valid  output  1  writeback tag valid this cycle
- wb_tag  output  5  destination register for writeback (oldest pending)
- src_a  input  5  decode-stage source register A
- src_b  input  5  decode-stage source register B
- hazard_a  output  1  src_a matches a pending tag
- hazard_b  output  1  src_b matches a pending tag
- count  output  CW  number of pending tags
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- err_overflow  output  1  sticky: push attempted while full
- err_underflow  output  1  sticky: done asserted while empty

Behaviour:
- Storage: circular buffer of DEPTH 5-bit entries, plus a valid bit per entry, rd_ptr, wr_ptr and count. Pointers wrap modulo DEPTH.
- Reset (sync, reset=1 at a rising edge):
  - count=0, rd_ptr=wr_ptr=0, all entry valid bits=0, err_overflow=err_underflow=0.
  - Outputs after reset: empty=1, full=0, issue_ready=1, wb_valid=0, hazard_a=hazard_b=0.
  - Reset overrides push, pop and error-setting in the same cycle. Reset mid-operation discards all pending tags.
- Push: push = issue_valid && !full.
  - Writes issue_tag at wr_ptr and sets that entry's valid bit; wr_ptr+1.
  - Tag 0 is stored (order preserved) but never produces a hazard.
- Pop: pop = done && !empty.
  - wb_valid = pop, combinational.
  - wb_tag = entry[rd_ptr], combinational (head), driven regardless of wb_valid.
  - On the edge: clear head valid bit, rd_ptr+1.
- Simultaneous push and pop:
  - Not full and not empty: both occur; count unchanged.
  - When full: push rejected (issue_ready=0 that cycle even though a pop occurs); pop proceeds; err_overflow set if issue_valid.
  - When empty: pop ignored; push proceeds; err_underflow set.
- count: +1 on push only, -1 on pop only, else hold. empty/full decoded from count.
- Errors:
  - err_overflow <= 1 when issue_valid && full.
  - err_underflow <= 1 when done && empty.
  - Both sticky until reset.
- Hazards (combinational, zero latency):
  - hazard_x = (src_x != 0) && OR over entries of (valid && entry == src_x).
  - A tag pushed in cycle N is visible from cycle N+1.
  - The entry being popped in cycle N still counts in cycle N (see Optional Feature) and is gone from N+1.
  - Duplicate pending tags are allowed; the hazard persists until the last copy pops.

Optional Feature:
- Macro: MD_SCOREBOARD_BYPASS_EN.
- Defined: the head entry is excluded from the hazard compare in any cycle where pop=1, because the writeback value is forwarded that cycle. Other matching entries still assert the hazard.
- Undefined: the head entry participates in the hazard compare until the edge after its pop.

Test Plan:
- Reset, then idle -> count=0, empty=1, issue_ready=1, wb_valid=0, hazard_a=hazard_b=0, both err flags 0.
- Push tags 5,9,0,31 on consecutive cycles; src_a=9, src_b=0 -> full=1, count=4; hazard_a=1; hazard_b=0 (r0 never hazards).
- From full, pulse done four times -> wb_tag sequence 5,9,0,31 with wb_valid=1 each pulse; then empty=1.
- Full and issue_valid=1 with done=1 in the same cycle -> head popped; push dropped; count=3; err_overflow=1 and stays 1 until reset.
- Pending {7}, src_a=7, done=1 -> hazard_a=1 without macro, 0 with MD_SCOREBOARD_BYPASS_EN; hazard_a=0 next cycle in both builds. Separately, done while empty -> err_underflow=1, count stays 0.
- Push 3 tags, then assert reset concurrently with issue_valid and done -> next cycle count=0, empty=1, no hazards; wrap test: 2*DEPTH+3 push/pop pairs preserve FIFO order.
